// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate-extension unit.
// Widens an IN_W-bit immediate to OUT_W bits (sign, zero, upper-load or
// branch-offset) and hands it downstream through a main register backed by
// a one-entry skid register. With that second entry, in_ready comes from
// registered state only and the unit can still run at one transfer per cycle.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] xfer_count
);

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_SHIFT2 = 2'b11;

    // Number of bits the immediate is shifted up by for UPPER.
    localparam int UP_SHIFT = OUT_W - IN_W;

    // Candidate extensions, built bit by bit so every width combination
    // (including IN_W == OUT_W) elaborates without out-of-range slices.
    logic [OUT_W-1:0] ext_sign;
    logic [OUT_W-1:0] ext_zero;
    logic [OUT_W-1:0] ext_upper;
    logic [OUT_W-1:0] ext_shift;
    logic [OUT_W-1:0] ext_result;

    // Main (M) and skid (S) entries.
    logic             m_valid_reg;
    logic [OUT_W-1:0] m_data_reg;
    logic [1:0]       m_mode_reg;
    logic             s_valid_reg;
    logic [OUT_W-1:0] s_data_reg;
    logic [1:0]       s_mode_reg;
    logic [CNT_W-1:0] xfer_count_reg;

    logic accept;
    logic xfer;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi = gi + 1) begin : g_ext
            // Low bits carry the immediate; high bits are sign or zero fill.
            if (gi < IN_W) begin : g_low
                assign ext_sign[gi] = in_data[gi];
                assign ext_zero[gi] = in_data[gi];
            end else begin : g_high
                assign ext_sign[gi] = in_data[IN_W-1];
                assign ext_zero[gi] = 1'b0;
            end

            // UPPER places the immediate in the top IN_W bits.
            if (gi >= UP_SHIFT) begin : g_up_data
                assign ext_upper[gi] = in_data[gi-UP_SHIFT];
            end else begin : g_up_zero
                assign ext_upper[gi] = 1'b0;
            end

            // SHIFT2 is the sign extension moved up two places; the top two
            // sign bits fall off and the two LSBs are zero.
            if (gi >= 2) begin : g_sh_data
                assign ext_shift[gi] = ext_sign[gi-2];
            end else begin : g_sh_zero
                assign ext_shift[gi] = 1'b0;
            end
        end
    endgenerate

    // Select the extension requested by the mode sampled with the data.
    always_comb begin
        ext_result = ext_sign;
        case (in_mode)
            MODE_SIGN:   ext_result = ext_sign;
            MODE_ZERO:   ext_result = ext_zero;
            MODE_UPPER:  ext_result = ext_upper;
            MODE_SHIFT2: ext_result = ext_shift;
            default:     ext_result = ext_sign;
        endcase
    end

    // Ready only reflects the skid entry, so it never waits on out_ready.
    assign in_ready = !s_valid_reg;
    assign accept   = in_valid && in_ready;
    assign xfer     = m_valid_reg && out_ready;

    // Two-entry buffer: M feeds the outputs, S absorbs one result while M stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_mode_reg  <= MODE_SIGN;
            s_valid_reg <= 1'b0;
            s_data_reg  <= '0;
            s_mode_reg  <= MODE_SIGN;
        end else if (xfer) begin
            // M is draining: refill from S first to keep FIFO order. An
            // accept cannot happen while S is full because in_ready is low.
            if (s_valid_reg) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= s_data_reg;
                m_mode_reg  <= s_mode_reg;
                s_valid_reg <= 1'b0;
            end else if (accept) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= ext_result;
                m_mode_reg  <= in_mode;
            end else begin
                m_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            // No drain this cycle: fill M if empty, otherwise park in S.
            if (!m_valid_reg) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= ext_result;
                m_mode_reg  <= in_mode;
            end else begin
                s_valid_reg <= 1'b1;
                s_data_reg  <= ext_result;
                s_mode_reg  <= in_mode;
            end
        end
    end

    // Count completed output transfers; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_reg <= '0;
        end else if (xfer) begin
            xfer_count_reg <= xfer_count_reg + CNT_W'(1);
        end
    end

    assign out_valid  = m_valid_reg;
    assign out_data   = m_data_reg;
    assign out_mode   = m_mode_reg;
    assign xfer_count = xfer_count_reg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: table-driven single transfers across all
// modes, then back-pressure, streaming, asynchronous reset and counter wrap.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic [15:0] xfer_count;

    // Second instance with a 4-bit counter for the wrap check.
    logic        w_in_valid;
    logic        w_in_ready;
    logic [15:0] w_in_data;
    logic [1:0]  w_in_mode;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_data;
    logic [1:0]  w_out_mode;
    logic [3:0]  w_xfer_count;

    int total;
    int bad;
    int exp_count;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_mode   (out_mode),
        .xfer_count (xfer_count)
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (w_in_valid),
        .in_ready   (w_in_ready),
        .in_data    (w_in_data),
        .in_mode    (w_in_mode),
        .out_valid  (w_out_valid),
        .out_ready  (w_out_ready),
        .out_data   (w_out_data),
        .out_mode   (w_out_mode),
        .xfer_count (w_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        total = total + 1;
        if (actual !== required) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, required);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        exp_count  = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_mode    = 2'b00;
        out_ready  = 1'b0;
        w_in_valid = 1'b0;
        w_in_data  = '0;
        w_in_mode  = 2'b00;
        w_out_ready = 1'b0;

        vecs[0] = '{2'b00, 16'hFFF6, 32'hFFFF_FFF6};
        vecs[1] = '{2'b00, 16'h7FFF, 32'h0000_7FFF};
        vecs[2] = '{2'b01, 16'hFFE2, 32'h0000_FFE2};
        vecs[3] = '{2'b10, 16'h1234, 32'h1234_0000};
        vecs[4] = '{2'b11, 16'hFFFE, 32'hFFFF_FFF8};
        vecs[5] = '{2'b11, 16'h4000, 32'h0001_0000};
        vecs[6] = '{2'b11, 16'h8000, 32'hFFFE_0000};
        vecs[7] = '{2'b01, 16'h8000, 32'h0000_8000};
        vecs[8] = '{2'b10, 16'hFFFF, 32'hFFFF_0000};
        vecs[9] = '{2'b00, 16'h8000, 32'hFFFF_8000};

        // Reset values, seen while reset is still held.
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_xfer_count", 64'(xfer_count), 64'd0);
        #10;
        rst = 1'b0;
        step();

        // Table: one accept, result one cycle later, drained the next cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            in_mode  = vecs[i].mode;
            check("vec_in_ready", 64'(in_ready), 64'd1);
            step();
            in_valid = 1'b0;
            check("vec_out_valid", 64'(out_valid), 64'd1);
            check("vec_out_data", 64'(out_data), 64'(vecs[i].exp_data));
            check("vec_out_mode", 64'(out_mode), 64'(vecs[i].mode));
            $display("vec %0d: mode=%0d in=0x%04h out=0x%08h", i, vecs[i].mode, vecs[i].data, out_data);
            step();
            exp_count = exp_count + 1;
            check("vec_drained", 64'(out_valid), 64'd0);
            check("vec_xfer_count", 64'(xfer_count), 64'(exp_count));
        end

        // Streaming: 10 back-to-back accepts with out_ready high.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100 + 16'(i);
            in_mode  = 2'b01;
            step();
            if (i > 0) exp_count = exp_count + 1;
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'h100 + 64'(i));
            $display("stream %0d: out=0x%08h", i, out_data);
        end
        in_valid = 1'b0;
        step();
        exp_count = exp_count + 1;
        check("stream_drained", 64'(out_valid), 64'd0);
        check("stream_xfer_count", 64'(xfer_count), 64'(exp_count));

        // Fill M and S under back-pressure, then reset between edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_data   = 16'h1111;
        step();
        in_data   = 16'h2222;
        step();
        in_valid  = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_xfer_count", 64'(xfer_count), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        $display("async reset: out_valid=%0d in_ready=%0d count=%0d", out_valid, in_ready, xfer_count);
        rst = 1'b0;
        exp_count = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_stale", 64'(out_valid), 64'd0);
        end

        // Back-pressure: -30, -20 accepted, -2 held until space frees.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_data   = 16'hFFE2;
        step();
        check("bp_first_valid", 64'(out_valid), 64'd1);
        check("bp_first_data", 64'(out_data), 64'hFFFF_FFE2);
        check("bp_ready_after_1", 64'(in_ready), 64'd1);
        in_data = 16'hFFEC;
        step();
        check("bp_ready_after_2", 64'(in_ready), 64'd0);
        in_data = 16'hFFFE;
        step();
        check("bp_held_ready", 64'(in_ready), 64'd0);
        check("bp_held_data", 64'(out_data), 64'hFFFF_FFE2);
        step();
        check("bp_held_data2", 64'(out_data), 64'hFFFF_FFE2);
        check("bp_count_idle", 64'(xfer_count), 64'd0);
        out_ready = 1'b1;
        step();
        exp_count = exp_count + 1;
        check("bp_out2_data", 64'(out_data), 64'hFFFF_FFEC);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        $display("bp: out=0x%08h in_ready=%0d", out_data, in_ready);
        step();
        exp_count = exp_count + 1;
        in_valid = 1'b0;
        check("bp_out3_valid", 64'(out_valid), 64'd1);
        check("bp_out3_data", 64'(out_data), 64'hFFFF_FFFE);
        $display("bp: out=0x%08h", out_data);
        step();
        exp_count = exp_count + 1;
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_xfer_count", 64'(xfer_count), 64'(exp_count));
        check("bp_xfer_count3", 64'(xfer_count), 64'd3);

        // Wrap: 17 transfers on the 4-bit counter instance.
        w_out_ready = 1'b1;
        w_in_mode   = 2'b00;
        for (int i = 0; i < 18; i++) begin
            w_in_valid = (i < 17);
            w_in_data  = 16'(i);
            step();
            if (i == 16) check("wrap_at_16", 64'(w_xfer_count), 64'd0);
        end
        check("wrap_count", 64'(w_xfer_count), 64'd1);
        check("wrap_drained", 64'(w_out_valid), 64'd0);
        $display("wrap: count=%0d", w_xfer_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. It widens an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper-load and branch-offset. It sits between the decode stage and the ALU operand mux, with valid/ready handshakes on both sides. A two-entry internal buffer (main plus skid) gives full throughput under back-pressure.

## Interface
- IN_W, 16, immediate input width; must satisfy 2 ≤ IN_W ≤ OUT_W.
- OUT_W, 32, extended output width.
- CNT_W, 16, width of the transfer counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- in_valid  in  1  upstream has an immediate.
- in_ready  out  1  unit can accept this cycle.
- in_data  in  IN_W  immediate.
- in_mode  in  2  00 SIGN, 01 ZERO, 10 UPPER, 11 SHIFT2.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  OUT_W  extended result.
- out_mode  out  2  mode that produced out_data.
- xfer_count  out  CNT_W  number of completed output transfers, modulo 2^CNT_W.

## Operation
- Extension is combinational on the input side; the result is registered before leaving the unit.
  - SIGN: in_data[IN_W-1] replicated into bits OUT_W-1..IN_W.
  - ZERO: upper OUT_W-IN_W bits are 0.
  - UPPER: in_data occupies bits OUT_W-1..OUT_W-IN_W; lower bits are 0. When IN_W = OUT_W, UPPER equals ZERO.
  - SHIFT2: SIGN result shifted left by 2. The top two bits are discarded; the two LSBs are 0.
- Storage: main register M (valid, data, mode) drives the outputs. Skid register S holds one extra result.
- in_ready = !S.valid. It is derived from registered state only and never depends combinationally on out_ready.
- Input accept (in_valid && in_ready) writes:
  - into M, if M is empty or M is draining this cycle;
  - otherwise into S.
- Output transfer (out_valid && out_ready):
  - if S is valid: M ← S and S is cleared;
  - else if an input is accepted in the same cycle: M ← new result;
  - otherwise: M.valid ← 0.
- An accept with no drain while M is valid fills S. in_ready drops the next cycle.
- Ordering is strictly FIFO: results never overtake each other.
- xfer_count increments by 1 on each output transfer. It wraps from 2^CNT_W-1 to 0 without saturating.
- in_mode is sampled with in_data at accept. Changing in_mode while a result is held has no effect on held results.
- Inputs are ignored while in_ready = 0. Upstream must keep in_valid and in_data stable until accepted.

## Timing
- Reset values: out_valid 0, out_data 0, out_mode 00, in_ready 1, xfer_count 0, S empty.
- Latency: an accept at edge N gives out_valid = 1 after edge N, i.e. 1 cycle.
- Throughput: 1 transfer per cycle while out_ready is held high.
- Back-pressure: with out_ready = 0, exactly two items are accepted. in_ready is 0 from the cycle after the second accept.
- After out_ready rises, S drains into M on the first transfer edge. in_ready returns to 1 the following cycle.
- Simultaneous accept and transfer with S empty: M is replaced and out_valid stays 1 with no bubble.
- Reset asserted mid-stream: outputs take their reset values immediately, asynchronously. Held data is discarded and xfer_count clears. The first accept after rst deasserts behaves as from cold.

## Test plan
- SIGN, IN_W = 16, OUT_W = 32: in_data 0xFFF6 (−10) → 0xFFFFFFF6. Then 0x7FFF → 0x00007FFF. Each appears one cycle after accept.
- ZERO / UPPER / SHIFT2: 0xFFE2 ZERO → 0x0000FFE2; 0x1234 UPPER → 0x12340000; 0xFFFE SHIFT2 → 0xFFFFFFF8; 0x4000 SHIFT2 → 0x00010000.
- Back-pressure: out_ready = 0, offer −30, −20, −2 on consecutive cycles.
  - −30 and −20 are accepted; in_ready = 0 and −2 is held.
  - Raise out_ready: outputs 0xFFFFFFE2, 0xFFFFFFEC, 0xFFFFFFFE appear in order.
  - xfer_count reaches 3.
- Streaming: out_ready = 1 and in_valid = 1 for 10 cycles with incrementing data. This gives 10 back-to-back transfers with no bubble.
- Wrap: CNT_W = 4, 17 transfers → xfer_count = 1.
- Reset mid-operation: with M and S full, pulse rst between edges.
  - out_valid = 0, in_ready = 1 and xfer_count = 0 immediately.
  - No stale data appears afterwards.
